// File: rtl/sram_mem_ctrl.sv
// MEM-stage word access controller for a 16-bit asynchronous SRAM (two halfword phases per word).
// Optional last-write forwarding buffer enabled with `define SRAM_LASTWR_FWD_EN.
module sram_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_DQ_oe,
    output logic               SRAM_WE_N
);

    localparam int unsigned WA   = SRAM_AW - 1;
    localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                wr_q;
    logic [WA-1:0]       w_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [SRAM_AW-1:0]  addr_q;
    logic [15:0]         dq_q;
    logic                oe_q;
    logic                we_n_q;

    logic                req;
    logic [WA-1:0]       w_in;
    logic [3:0]          cnt_d;
    logic                fwd_hit;
    logic [31:0]         fwd_rdata;

    assign req   = mem_read | mem_write;
    // Word index wraps onto the SRAM: bits above the halfword address width are dropped.
    assign w_in  = WA'((address - BASE_ADDR) >> 2);
    assign cnt_d = cnt_q + 4'd1;

`ifdef SRAM_LASTWR_FWD_EN
    logic          fwd_valid_q;
    logic [WA-1:0] fwd_w_q;
    logic [31:0]   fwd_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid_q <= 1'b0;
            fwd_w_q     <= '0;
            fwd_data_q  <= '0;
        end else if (state_q == DONE && wr_q) begin
            fwd_valid_q <= 1'b1;
            fwd_w_q     <= w_q;
            fwd_data_q  <= wdata_q;
        end
    end

    assign fwd_hit   = mem_read & ~mem_write & fwd_valid_q & (fwd_w_q == w_in);
    assign fwd_rdata = fwd_data_q;
`else
    assign fwd_hit   = 1'b0;
    assign fwd_rdata = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            w_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q    <= mem_write;
                        w_q     <= w_in;
                        wdata_q <= write_data;
                        cnt_q   <= '0;
                        if (fwd_hit) begin
                            rdata_q <= fwd_rdata;
                            state_q <= DONE;
                        end else begin
                            state_q <= LOW;
                            addr_q  <= {w_in, 1'b0};
                            dq_q    <= write_data[15:0];
                            oe_q    <= mem_write;
                            we_n_q  <= ~mem_write;
                        end
                    end
                end
                LOW: begin
                    if (cnt_q == LAST) begin
                        if (!wr_q) begin
                            rdata_q[15:0] <= SRAM_DQ_in;
                        end
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        addr_q  <= {w_q, 1'b1};
                        dq_q    <= wdata_q[31:16];
                        we_n_q  <= ~wr_q;
                    end else begin
                        cnt_q  <= cnt_d;
                        // Strobe released on the final cycle of the phase to hold data.
                        we_n_q <= ~wr_q | (cnt_d == LAST);
                    end
                end
                HIGH: begin
                    if (cnt_q == LAST) begin
                        if (!wr_q) begin
                            rdata_q[31:16] <= SRAM_DQ_in;
                        end
                        state_q <= DONE;
                        cnt_q   <= '0;
                        oe_q    <= 1'b0;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_d;
                        we_n_q <= ~wr_q | (cnt_d == LAST);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready       = ~rst | ((state_q == IDLE) & ~req) | (state_q == DONE);
    assign read_data   = rdata_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = dq_q;
    assign SRAM_DQ_oe  = oe_q;
    assign SRAM_WE_N   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: behavioural SRAM plus word-level reference model and randomized traffic.
module tb_sram_mem_ctrl;

    localparam int W  = 3;
    localparam int AW = 18;
`ifdef SRAM_LASTWR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [31:0]   address = '0;
    logic [31:0]   write_data = '0;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_DQ_out;
    logic [15:0]   SRAM_DQ_in;
    logic          SRAM_DQ_oe;
    logic          SRAM_WE_N;

    sram_mem_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
        .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    logic [15:0] sram [0:(1<<AW)-1];
    assign SRAM_DQ_in = sram[SRAM_ADDR];
    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR] <= SRAM_DQ_out;
    end

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]  ref_word [int unsigned];
    int unsigned  wr_addrs [$];
    logic [31:0]  rd_model = '0;
    bit           fwd_v = 1'b0;
    int unsigned  fwd_k = 0;
    logic [31:0]  fwd_d = '0;
    bit           last_done = 1'b0;

    function automatic int unsigned wkey(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'd1024;
        return (d >> 2) % (1 << (AW - 1));
    endfunction

    task automatic go_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (last_done) begin
            @(negedge clk); #1;
        end
        last_done = 1'b0;
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int unsigned wk;
        bit          hit;
        int          lowc, wel, exp_low;
        bit          oebad, moved;
        logic [AW-1:0] a0;
        logic [31:0] exp_rd;
        wk  = wkey(addr);
        hit = FWD && fwd_v && (fwd_k == wk) && rd && !wr;
        mem_read = rd; mem_write = wr; address = addr; write_data = data;
        if (last_done) @(negedge clk);
        #1;
        lowc = 0; wel = 0; oebad = 0; moved = 0; a0 = SRAM_ADDR;
        while (!ready && lowc < 200) begin
            lowc++;
            if (!SRAM_WE_N) begin
                wel++;
                if (!SRAM_DQ_oe) oebad = 1;
            end
            if (SRAM_ADDR !== a0) moved = 1;
            @(negedge clk); #1;
        end
        last_done = 1'b1;
        exp_low = hit ? 1 : 1 + 2 * W;
        vectors++;
        if (lowc !== exp_low) begin
            miscompares++;
            $display("FAIL ready_low addr=%h: got %0d cycles, expected %0d", addr, lowc, exp_low);
        end
        if (wr) begin
            ref_word[wk] = data;
            wr_addrs.push_back(addr);
            fwd_v = 1'b1; fwd_k = wk; fwd_d = data;
            vectors++;
            if (wel !== 2 * (W - 1) || oebad) begin
                miscompares++;
                $display("FAIL we_strobe addr=%h: got %0d low cycles oebad=%0d, expected %0d", addr, wel, oebad, 2*(W-1));
            end
            vectors++;
            if (sram[2*wk] !== data[15:0] || sram[2*wk+1] !== data[31:16]) begin
                miscompares++;
                $display("FAIL sram_halves w=%h: got %h_%h, expected %h", wk, sram[2*wk+1], sram[2*wk], data);
            end
            vectors++;
            if (read_data !== rd_model) begin
                miscompares++;
                $display("FAIL rd_kept_on_write: got %h, expected %h", read_data, rd_model);
            end
        end else begin
            exp_rd = hit ? fwd_d : ref_word[wk];
            rd_model = exp_rd;
            vectors++;
            if (read_data !== exp_rd) begin
                miscompares++;
                $display("FAIL read_data addr=%h: got %h, expected %h", addr, read_data, exp_rd);
            end
            vectors++;
            if (wel !== 0 || (hit && moved)) begin
                miscompares++;
                $display("FAIL read_bus addr=%h: got we_low=%0d moved=%0d, expected 0/0", addr, wel, moved);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0 || read_data !== 32'h0 ||
            SRAM_ADDR !== '0 || SRAM_DQ_out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b we_n=%b oe=%b rd=%h addr=%h dq=%h, expected 1 1 0 0 0 0",
                     ready, SRAM_WE_N, SRAM_DQ_oe, read_data, SRAM_ADDR, SRAM_DQ_out);
        end
        mem_write = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_in_reset: got %b, expected 1", ready);
        end
        mem_write = 1'b0;
        @(negedge clk); rst = 1'b1; #1;

        txn(0, 1, 32'd1024 + 32'd40, 32'hCAFEF00D);
        txn(1, 0, 32'd1024 + 32'd40, 32'h0);
        go_idle();
        mem_write = 1'b1; address = 32'd1024 + 32'd800; write_data = 32'h0BADF00D;
        repeat (W + 1) @(negedge clk);
        #1;
        vectors++;
        if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== AW'(401)) begin
            miscompares++;
            $display("FAIL high_phase_write: got we_n=%b addr=%h, expected 0 %h", SRAM_WE_N, SRAM_ADDR, AW'(401));
        end
        rst = 1'b0; mem_write = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0 || read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got rdy=%b we_n=%b oe=%b rd=%h, expected 1 1 0 0",
                     ready, SRAM_WE_N, SRAM_DQ_oe, read_data);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (ready !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: got rdy=%b we_n=%b oe=%b, expected 1 1 0", ready, SRAM_WE_N, SRAM_DQ_oe);
        end
        rd_model = 32'h0; fwd_v = 1'b0; last_done = 1'b0;
    endtask

    task automatic test_directed();
        txn(0, 1, 32'd1024, 32'hDEADBEEF);
        vectors++;
        if (sram[0] !== 16'hBEEF || sram[1] !== 16'hDEAD) begin
            miscompares++;
            $display("FAIL deadbeef_halves: got [0]=%h [1]=%h, expected BEEF DEAD", sram[0], sram[1]);
        end
        go_idle();
        txn(1, 0, 32'd1024, 32'h0);
        go_idle();
        txn(0, 1, 32'd1032, 32'h12345678);
        txn(1, 0, 32'd1032, 32'h0);
        vectors++;
        if (sram[4] !== 16'h5678 || sram[5] !== 16'h1234 || read_data !== 32'h12345678) begin
            miscompares++;
            $display("FAIL b2b_1032: got [4]=%h [5]=%h rd=%h, expected 5678 1234 12345678", sram[4], sram[5], read_data);
        end
        txn(1, 1, 32'd1028, 32'hA5A55A5A);
        vectors++;
        if (sram[2] !== 16'h5A5A || sram[3] !== 16'hA5A5 || read_data !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rdwr_1028: got [2]=%h [3]=%h rd=%h, expected 5A5A A5A5 12345678", sram[2], sram[3], read_data);
        end
        go_idle();
    endtask

    task automatic test_wrap();
        txn(0, 1, 32'd1020, 32'h0F0E0D0C);
        vectors++;
        if (sram[AW'(18'h3FFFE)] !== 16'h0D0C || sram[AW'(18'h3FFFF)] !== 16'h0F0E) begin
            miscompares++;
            $display("FAIL wrap_1020: got %h_%h, expected 0F0E_0D0C", sram[AW'(18'h3FFFF)], sram[AW'(18'h3FFFE)]);
        end
        txn(0, 1, 32'd1027, 32'h77665544);
        txn(1, 0, 32'd0, 32'h0);
        go_idle();
    endtask

    task automatic test_forward();
        txn(0, 1, 32'd1044, 32'h33334444);
        go_idle();
        txn(0, 1, 32'd1040, 32'h11112222);
        go_idle();
        txn(1, 0, 32'd1040, 32'h0);
        go_idle();
        txn(1, 0, 32'd1044, 32'h0);
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int unsigned sel, k;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            k   = $urandom_range(0, 47);
            if ($urandom_range(0, 7) == 0) a = 32'd1024 - 32'(4 * (k + 1));
            else a = 32'd1024 + 32'(4 * k);
            a = a | 32'($urandom_range(0, 3));
            if (sel < 4 && wr_addrs.size() > 0) begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                txn(1, 0, a, 32'h0);
            end else if (sel == 4 && wr_addrs.size() > 0) begin
                txn(1, 0, wr_addrs[wr_addrs.size() - 1], 32'h0);
            end else if (sel == 5) begin
                txn(1, 1, a, $urandom);
            end else begin
                txn(0, 1, a, $urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                go_idle();
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk); #1;
                end
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wrap();
        test_forward();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
